// File: rtl/dsp_sched.sv
// dsp_sched -- two-requester time-sharing arbiter for the 8-digit 7-segment display.
//
// Two requesters each present a complete 64-bit segment image (digit 0 in
// bits [7:0]). Ownership is granted round-robin with a minimum dwell time. A
// blank gap is inserted on every owner change, so the driver never shows a
// mixture of two images.
//
// Parameters:
//   DWELL  minimum ownership, in tick pulses, before a competing request can preempt
//   GAP    blank interval between owners, in tick pulses (1..1023)
//   CW     tick counter width; must hold max(DWELL, GAP)
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   tick      one-clk-wide time-base enable
//   req0/1    requester wants the display (level)
//   data0/1   requester segment images, active-high segments
//   gnt0/1    requester currently owns the display
//   dsp_data  image to the display driver; all-zero when blank
//   busy      high whenever the arbiter is not idle
module dsp_sched #(
  parameter int DWELL = 1000,
  parameter int GAP   = 2,
  parameter int CW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] data0,
  input  logic [63:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [63:0] dsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    GAP_S = 2'd3
  } state_t;

  localparam logic [CW-1:0] DWELL_C = CW'(DWELL);
  localparam logic [CW-1:0] GAP_C   = CW'(GAP);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last, last_n;

  logic          gnt0_n, gnt1_n, busy_n;
  logic [63:0]   data_n;

  logic [1:0]    win;
  logic          own_req, oth_req;

  // Round-robin choice: returns {valid, winner}. On a tie the requester that
  // did not own the display most recently wins.
  function automatic logic [1:0] pick(input logic r0, input logic r1,
                                      input logic lst);
    if (r0 && r1)
      return {1'b1, ~lst};
    else if (r0)
      return 2'b10;
    else if (r1)
      return 2'b11;
    else
      return 2'b00;
  endfunction

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    win     = pick(req0, req1, last);
    own_req = (state == OWN1) ? req1 : req0;
    oth_req = (state == OWN1) ? req0 : req1;

    case (state)
      IDLE: begin
        // Not tick-gated: a new request is served on the very next edge.
        if (win[1]) begin
          state_n = win[0] ? OWN1 : OWN0;
          cnt_n   = '0;
          last_n  = win[0];
        end
      end

      OWN0, OWN1: begin
        // A release always takes priority over a coincident tick; the tick
        // is simply lost because the counter restarts on the next owner.
        if (!own_req) begin
          state_n = oth_req ? GAP_S : IDLE;
          cnt_n   = '0;
        end else if (oth_req && (cnt == DWELL_C)) begin
          state_n = GAP_S;
          cnt_n   = '0;
        end else if (tick && (cnt != DWELL_C)) begin
          cnt_n = cnt + 1'b1;
        end
      end

      GAP_S: begin
        // last still holds the previous owner here, so a tie goes to the
        // other requester.
        if (cnt == GAP_C) begin
          cnt_n = '0;
          if (win[1]) begin
            state_n = win[0] ? OWN1 : OWN0;
            last_n  = win[0];
          end else begin
            state_n = IDLE;
          end
        end else if (tick) begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they move on the same
    // edge as the state register.
    gnt0_n = (state_n == OWN0);
    gnt1_n = (state_n == OWN1);
    busy_n = (state_n != IDLE);
    case (state_n)
      OWN0:    data_n = data0;
      OWN1:    data_n = data1;
      default: data_n = '0;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      dsp_data <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last     <= last_n;
      gnt0     <= gnt0_n;
      gnt1     <= gnt1_n;
      busy     <= busy_n;
      dsp_data <= data_n;
    end
  end

  // Simulation-only sanity checks on parameters and output invariants.
  always_ff @(posedge clk) begin
    assert (DWELL >= 0 && DWELL <= (2**CW) - 1)
      else $error("dsp_sched: DWELL does not fit in CW bits");
    assert (GAP >= 1 && GAP <= 1023 && GAP <= (2**CW) - 1)
      else $error("dsp_sched: GAP out of range");
    if (!rst) begin
      assert (!(gnt0 && gnt1))
        else $error("dsp_sched: both grants high");
      assert (gnt0 || gnt1 || (dsp_data == 64'd0))
        else $error("dsp_sched: image shown without a grant");
    end
  end

endmodule

// File: tb/tb_dsp_sched.sv
// tb_dsp_sched -- randomized and directed bench for dsp_sched with a
// behavioural reference model (DWELL=4, GAP=2, tick every 5 clk).
module tb_dsp_sched;

  localparam int DWELL = 4;
  localparam int GAP   = 2;
  localparam int CW    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [63:0] data0 = '0;
  logic [63:0] data1 = '0;
  logic        gnt0, gnt1, busy;
  logic [63:0] dsp_data;

  dsp_sched #(.DWELL(DWELL), .GAP(GAP), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .req0     (req0),
    .req1     (req1),
    .data0    (data0),
    .data1    (data1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .dsp_data (dsp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference model: who owns the display (-1 nobody, 0/1 requester, 2 blank
  // gap), ticks counted in the current phase, and the most recent owner.
  int          m_owner = -1;
  int          m_ticks = 0;
  int          m_last  = 1;
  logic [63:0] m_img   = '0;
  int          tphase  = 0;

  function automatic int choose(input logic r0, input logic r1, input int lst);
    if (r0 && r1) return (lst == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    bit mine, other;
    if (rst) begin
      m_owner = -1; m_ticks = 0; m_last = 1;
    end else if (m_owner == -1) begin
      w = choose(req0, req1, m_last);
      if (w >= 0) begin m_owner = w; m_ticks = 0; m_last = w; end
    end else if (m_owner == 2) begin
      if (m_ticks == GAP) begin
        w = choose(req0, req1, m_last);
        m_ticks = 0;
        if (w >= 0) begin m_owner = w; m_last = w; end
        else m_owner = -1;
      end else if (tick) m_ticks++;
    end else begin
      mine  = (m_owner == 0) ? req0 : req1;
      other = (m_owner == 0) ? req1 : req0;
      if (!mine) begin
        m_owner = other ? 2 : -1; m_ticks = 0;
      end else if (other && m_ticks >= DWELL) begin
        m_owner = 2; m_ticks = 0;
      end else if (tick && m_ticks < DWELL) m_ticks++;
    end
    m_img = (m_owner == 0) ? data0 : (m_owner == 1) ? data1 : 64'd0;
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, compare just after it.
  task automatic step(input logic r, input logic q0, input logic q1, input logic tk);
    @(negedge clk);
    rst = r; req0 = q0; req1 = q1; tick = tk;
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt0", {63'd0, gnt0}, {63'd0, (m_owner == 0)});
    chk("gnt1", {63'd0, gnt1}, {63'd0, (m_owner == 1)});
    chk("busy", {63'd0, busy}, {63'd0, (m_owner != -1)});
    chk("dsp_data", dsp_data, m_img);
  endtask

  // Same, with the regular 1-in-5 time base.
  task automatic astep(input logic r, input logic q0, input logic q1);
    tphase = (tphase + 1) % 5;
    step(r, q0, q1, (tphase == 0));
  endtask

  initial begin
    data0 = 64'h3F06_5B4F_666D_7D07;
    data1 = 64'h7F6F_7739_5E79_7138;

    // Reset held 2 clk with req0 set, then released.
    astep(1, 1, 0);
    astep(1, 1, 0);
    chk("rst_gnt0", {63'd0, gnt0}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    astep(0, 1, 0);
    chk("rel_gnt0", {63'd0, gnt0}, 64'd1);
    chk("rel_img", dsp_data, 64'h3F06_5B4F_666D_7D07);

    // Lone owner: image tracking and 20+ ticks without a gap.
    for (int i = 0; i < 105; i++) begin
      if (i == 10) data0 = 64'h0102_0304_0506_0708;
      astep(0, 1, 0);
      if (i == 10) chk("track_img", dsp_data, 64'h0102_0304_0506_0708);
    end
    chk("hold_gnt0", {63'd0, gnt0}, 64'd1);

    // Release coinciding with a tick, no other requester.
    step(0, 0, 0, 1);
    chk("reltick_busy", {63'd0, busy}, 64'd0);
    chk("reltick_img", dsp_data, 64'd0);

    // Tie from IDLE after reset: requester 0 first, preempted after dwell.
    astep(1, 0, 0);
    astep(0, 1, 1);
    chk("tie_gnt0", {63'd0, gnt0}, 64'd1);
    for (int i = 0; i < 40; i++) begin
      data1 = {$urandom, $urandom};
      astep(0, 1, 1);
    end
    // Owner 1 (if it is) releases early; model follows either way.
    for (int i = 0; i < 8; i++) astep(0, 1, 1);
    for (int i = 0; i < 20; i++) astep(0, 1, m_owner == 1 ? 1'b0 : 1'b1);

    // Reset in the middle of a gap with both requests held.
    for (int i = 0; i < 80 && m_owner != 2; i++) astep(0, 1, 1);
    chk("in_gap", {63'd0, busy && !gnt0 && !gnt1}, 64'd1);
    astep(1, 1, 1);
    astep(0, 1, 1);
    chk("gaprst_gnt0", {63'd0, gnt0}, 64'd1);

    // Randomized traffic: slowly varying requests, random images, mixed
    // time bases and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic q0, q1, r, tk;
      q0 = ($urandom_range(0, 39) == 0) ? ~req0 : req0;
      q1 = ($urandom_range(0, 39) == 0) ? ~req1 : req1;
      r  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) data0 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) data1 = {$urandom, $urandom};
      if (i < 1500) begin
        tphase = (tphase + 1) % 5;
        tk = (tphase == 0);
      end else begin
        tk = ($urandom_range(0, 2) == 0);
      end
      step(r, q0, q1, tk);
      chk("excl", {63'd0, gnt0 & gnt1}, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
